thresh_chain_loader: RTL
========================

Name: thresh_chain_loader

Overview:
- Parametrised successor to the comparator-threshold load FSM.
- Serially shifts NDEV daisy-chained DW-bit threshold words from a parallel bus, MSB first, most distant device first.
- Issues a latch strobe after the last bit, then holds a done flag until the request is withdrawn.
- Sits between the slow-control register block and the comparator DAC chain.
- All state registers update on the falling edge of CLK, so the serial devices sample on the rising edge.

Parameters:
- DW, 16, bits per device word (2..32).
- NDEV, 1, number of devices in the chain (1..16).
- LOAD_W, 2, width of the latch strobe in CLK cycles (1..15).

Ports:
- CLK  in  1  system clock; all registers use its falling edge.
- RST  in  1  reset, asynchronous, active-high.
- START  in  1  level request; must stay high until SET_DONE is seen.
- DATA  in  NDEV*DW  threshold words; device d occupies bits [d*DW +: DW]; device NDEV-1 is shifted first.
- SDATA  out  1  serial data; valid whenever SHFT_ENA=1.
- SHFT_ENA  out  1  shift-clock enable for the chain.
- LOAD  out  1  latch strobe to the chain.
- BUSY  out  1  high in PLOAD, SHIFT and STROBE.
- SET_DONE  out  1  load complete; high in DONE.
- ABORTED  out  1  sticky flag: START fell before DONE was reached.

Behaviour:
- Reset values: all outputs 0, state IDLE, shift register 0, all counters 0.
- Outputs are registered from nextstate (Moore-registered), with no combinational path from START.
- States and transitions:
  - IDLE: START=1 goes to PLOAD; ABORTED clears on this transition.
  - PLOAD: one cycle. The shift register captures DATA with device NDEV-1 word at the MSB end. Bit counter = 0, device counter = 0. Next state is SHIFT.
  - SHIFT: SHFT_ENA=1 and SDATA = shift register MSB. The register shifts left by one at every falling edge.
    - The bit counter wraps at DW-1 and increments the device counter.
    - After exactly NDEV*DW SHIFT cycles, next state is STROBE.
  - STROBE: LOAD=1 for exactly LOAD_W cycles, counted by the strobe counter. Then next state is DONE.
  - DONE: SET_DONE=1; SDATA=0. START=0 goes to IDLE.
- Latency: START sampled high at edge 0 gives PLOAD at edge 0 and the first SHFT_ENA at edge 1. LOAD spans edges 1+NDEV*DW .. NDEV*DW+LOAD_W. SET_DONE rises at edge 1+NDEV*DW+LOAD_W.
- Abort: START=0 in PLOAD, SHIFT or STROBE goes to IDLE at the next edge.
  - SHFT_ENA, LOAD and BUSY drop at that edge.
  - ABORTED sets and SET_DONE is never asserted.
  - A partial shift leaves the chain contents undefined, and software must reload.
- Reset mid-operation: everything returns immediately to reset values and no LOAD pulse is emitted.
- START held high through DONE: stays in DONE, with no automatic reload.
- DATA is sampled only in PLOAD; later changes have no effect on the word being shifted.
- Counter widths: bit counter $clog2(DW); device counter max(1,$clog2(NDEV)); strobe counter 4 bits. All comparisons are at full width, with no wrap-around before the terminal count.
- Undefined state encodings recover to IDLE at the next edge.

Optional Feature:
- Macro: THRESH_CHAIN_LOADER_TMR_EN.
- Defined:
  - State, counters, shift register and output registers are triplicated with syn_preserve.
  - Each copy computes its next value from the majority-voted state and counters, so a single upset is scrubbed in one cycle.
  - Outputs are the bitwise majority vote of the three copies.
- Undefined: a single copy with identical cycle behaviour.

Decomposition:
- Shared package thresh_pkg: state enum (IDLE, PLOAD, SHIFT, STROBE, DONE; 3-bit encoding) and the function clog2_min1.
- Sub-module tmr_vote #(W): 3-input bitwise majority voter, instantiated only under the macro.

Test Plan:
- DW=16, NDEV=1, DATA=16'hA5C3, START held:
  - SHFT_ENA high for exactly 16 cycles, and SDATA sequence equals 1010_0101_1100_0011.
  - LOAD is high for 2 cycles, then SET_DONE=1.
  - Dropping START gives IDLE next edge, with SET_DONE=0.
- DW=12, NDEV=3, DATA={12'h111,12'h222,12'h333}:
  - 36 shift cycles, with the 12'h111 bits first.
  - SET_DONE rises at edge 1+36+2=39.
- Abort: START dropped after 5 shift cycles gives IDLE next edge, with SHFT_ENA=0, ABORTED=1 and no LOAD pulse. The next START clears ABORTED.
- RST asserted during STROBE: LOAD, BUSY and SET_DONE go to 0 asynchronously, and a subsequent START completes a normal load.
- DATA changed during SHIFT: the serial stream still matches the value captured in PLOAD.
- TMR build: force one copy's state register to a wrong value mid-shift. The output sequence is unchanged and all three copies agree within 1 cycle.

Source files
------------

// File: rtl/thresh_pkg.sv
// Shared types for the threshold chain loader: FSM state encoding and width helper.
package thresh_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PLOAD  = 3'd1,
    SHIFT  = 3'd2,
    STROBE = 3'd3,
    DONE   = 3'd4
  } state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tmr_vote.sv
// Bitwise 2-of-3 majority voter.
module tmr_vote #(
  parameter int W = 1
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  output logic [W-1:0] y_o
);

  assign y_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/thresh_chain_loader.sv
// Serial loader for a daisy chain of NDEV comparator threshold DACs, falling-edge clocked.
// Define THRESH_CHAIN_LOADER_TMR_EN to triplicate all registers behind a majority voter.
//
// state  | meaning
// IDLE   | waiting for START
// PLOAD  | capture DATA into the shift register
// SHIFT  | shift NDEV*DW bits out, MSB first
// STROBE | LOAD high for LOAD_W cycles
// DONE   | SET_DONE high until START drops
module thresh_chain_loader
  import thresh_pkg::*;
#(
  parameter int DW     = 16,
  parameter int NDEV   = 1,
  parameter int LOAD_W = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic [NDEV*DW-1:0] DATA,
  output logic               SDATA,
  output logic               SHFT_ENA,
  output logic               LOAD,
  output logic               BUSY,
  output logic               SET_DONE,
  output logic               ABORTED
);

  localparam int N   = NDEV * DW;
  localparam int BW  = $clog2(DW);
  localparam int DVW = clog2_min1(NDEV);
  localparam int RW  = 3 + BW + DVW + 4 + N + 6;

  logic [RW-1:0]  cur, nxt;
  logic [2:0]     st_bits;
  state_t         state_q, state_d;
  logic [BW-1:0]  bcnt_q, bcnt_d;
  logic [DVW-1:0] dcnt_q, dcnt_d;
  logic [3:0]     scnt_q, scnt_d;
  logic [N-1:0]   sreg_q, sreg_d;
  logic [5:0]     outs_q, outs_d;
  logic           aborted_d;

  // All registered fields live in one vector so the TMR build can vote them as a unit.
  assign {st_bits, bcnt_q, dcnt_q, scnt_q, sreg_q, outs_q} = cur;
  assign state_q = state_t'(st_bits);
  assign nxt = {state_d, bcnt_d, dcnt_d, scnt_d, sreg_d, outs_d};

  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    dcnt_d    = dcnt_q;
    scnt_d    = scnt_q;
    sreg_d    = sreg_q;
    aborted_d = outs_q[0];
    case (state_q)
      IDLE: begin
        if (START) begin
          state_d   = PLOAD;
          aborted_d = 1'b0;
        end
      end
      PLOAD: begin
        bcnt_d = '0;
        dcnt_d = '0;
        if (!START) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else begin
          state_d = SHIFT;
          sreg_d  = DATA;
        end
      end
      SHIFT: begin
        if (!START) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else begin
          sreg_d = sreg_q << 1;
          if (bcnt_q == BW'(DW - 1)) begin
            bcnt_d = '0;
            if (dcnt_q == DVW'(NDEV - 1)) begin
              state_d = STROBE;
              scnt_d  = '0;
            end else begin
              dcnt_d = dcnt_q + DVW'(1);
            end
          end else begin
            bcnt_d = bcnt_q + BW'(1);
          end
        end
      end
      STROBE: begin
        if (!START) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (scnt_q == 4'(LOAD_W - 1)) begin
          state_d = DONE;
        end else begin
          scnt_d = scnt_q + 4'd1;
        end
      end
      DONE: begin
        if (!START) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they change on the same edge as the state.
    outs_d = {(state_d == SHIFT) ? sreg_d[N-1] : 1'b0,
              state_d == SHIFT,
              state_d == STROBE,
              (state_d == PLOAD) || (state_d == SHIFT) || (state_d == STROBE),
              state_d == DONE,
              aborted_d};
  end

`ifdef THRESH_CHAIN_LOADER_TMR_EN
  (* syn_preserve = 1 *) logic [RW-1:0] regs_q [3];

  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 3; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) regs_q[i] <= nxt;
    end
  end

  tmr_vote #(.W(RW)) u_vote (
    .a_i(regs_q[0]),
    .b_i(regs_q[1]),
    .c_i(regs_q[2]),
    .y_o(cur)
  );
`else
  logic [RW-1:0] regs_q;

  always_ff @(negedge CLK or posedge RST) begin
    if (RST) regs_q <= '0;
    else     regs_q <= nxt;
  end

  assign cur = regs_q;
`endif

  assign {SDATA, SHFT_ENA, LOAD, BUSY, SET_DONE, ABORTED} = outs_q;

endmodule
